// File: rtl/slot_alloc_table.sv
// slot_alloc_table: tracks busy/ready state of ALU/RS slots and offers two free slots
// and two round-robin issue candidates per cycle.
module slot_alloc_table #(
    parameter int SLOTS = 6,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    input  logic             alloc_req_1,
    input  logic             alloc_req_2,
    output logic             alloc_gnt_1,
    output logic             alloc_gnt_2,
    output logic [IDX_W-1:0] free_idx_1,
    output logic [IDX_W-1:0] free_idx_2,
    input  logic [SLOTS-1:0] release_mask,
    input  logic [SLOTS-1:0] ready_set,
    output logic [IDX_W-1:0] issue_idx_1,
    output logic [IDX_W-1:0] issue_idx_2,
    input  logic             issue_ack_1,
    input  logic             issue_ack_2,
    output logic [IDX_W:0]   busy_cnt,
    output logic             full
);
    localparam logic [IDX_W-1:0] NONE = '1;

    logic [SLOTS-1:0] busy_q, busy_d, ready_q, ready_d, gnt_mask, ack_mask;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] free1_q, free1_d, free2_q, free2_d, iss1_q, iss1_d, iss2_q, iss2_d;
    logic [IDX_W:0]   cnt_q, cnt_d, pos;
    logic             full_q, full_d, ack1, ack2;

    function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(SLOTS - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign free_idx_1  = free1_q;
    assign free_idx_2  = free2_q;
    assign issue_idx_1 = iss1_q;
    assign issue_idx_2 = iss2_q;
    assign busy_cnt    = cnt_q;
    assign full        = full_q;

    // Flush is folded into the next-state so every derived output falls out as its reset value
    always_comb begin
        alloc_gnt_1 = rdy & ~flush & alloc_req_1 & (free1_q != NONE);
        alloc_gnt_2 = alloc_gnt_1 & alloc_req_2 & (free2_q != NONE);
        ack1        = rdy & ~flush & issue_ack_1 & (iss1_q != NONE);
        ack2        = ack1 & issue_ack_2 & (iss2_q != NONE);
        gnt_mask    = (alloc_gnt_1 ? SLOTS'(1) << free1_q : '0) | (alloc_gnt_2 ? SLOTS'(1) << free2_q : '0);
        ack_mask    = (ack1 ? SLOTS'(1) << iss1_q : '0) | (ack2 ? SLOTS'(1) << iss2_q : '0);
        busy_d      = flush ? '0 : (busy_q & ~release_mask) | gnt_mask;
        ready_d     = flush ? '0 : ((ready_q & ~ack_mask) | ready_set) & busy_d;
        rr_ptr_d    = flush ? '0 : ack2 ? inc(iss2_q) : ack1 ? inc(iss1_q) : rr_ptr_q;
    end

    // Downward scans: the last hit is the first in order, the previous hit is the second
    always_comb begin
        free1_d = NONE;
        free2_d = NONE;
        iss1_d  = NONE;
        iss2_d  = NONE;
        cnt_d   = '0;
        pos     = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            cnt_d = cnt_d + {{IDX_W{1'b0}}, busy_d[i]};
            if (!busy_d[i]) begin
                free2_d = free1_d;
                free1_d = IDX_W'(i);
            end
        end
        for (int k = SLOTS - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr_d} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(SLOTS))
                pos = pos - (IDX_W+1)'(SLOTS);
            if (ready_d[pos[IDX_W-1:0]]) begin
                iss2_d = iss1_d;
                iss1_d = pos[IDX_W-1:0];
            end
        end
        full_d = (cnt_d == (IDX_W+1)'(SLOTS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            ready_q  <= '0;
            rr_ptr_q <= '0;
            free1_q  <= '0;
            free2_q  <= IDX_W'(1);
            iss1_q   <= NONE;
            iss2_q   <= NONE;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else if (rdy) begin
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            rr_ptr_q <= rr_ptr_d;
            free1_q  <= free1_d;
            free2_q  <= free2_d;
            iss1_q   <= iss1_d;
            iss2_q   <= iss2_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
        end
    end
endmodule

// File: tb/tb_slot_alloc_table.sv
// tb_slot_alloc_table: directed stimulus with a slot-list model compared every cycle.
module tb_slot_alloc_table;
    localparam int N = 6;
    localparam int NONE = 7;

    logic clk = 0, rst_n = 1, rdy = 1, flush = 0;
    logic req1 = 0, req2 = 0, ack1 = 0, ack2 = 0;
    logic [N-1:0] rel = '0, rset = '0;
    logic g1, g2, full;
    logic [2:0] f1, f2, i1, i2;
    logic [3:0] cnt;
    int checks = 0, failures = 0;

    bit mb[N];
    bit mr[N];
    int mrr = 0;

    localparam logic [17:0] VEC [8] = '{
        18'b1_0_1_1_0_0_000000_000011,
        18'b1_0_1_0_1_1_100001_000100,
        18'b1_0_0_0_1_0_000000_111111,
        18'b0_0_1_1_1_1_111111_000000,
        18'b1_0_1_1_1_1_000010_001000,
        18'b1_0_1_1_0_0_000000_000000,
        18'b1_0_1_1_1_1_010101_101010,
        18'b1_1_1_1_1_1_000000_111111
    };

    slot_alloc_table #(.SLOTS(N), .IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .alloc_req_1(req1), .alloc_req_2(req2),
        .alloc_gnt_1(g1), .alloc_gnt_2(g2),
        .free_idx_1(f1), .free_idx_2(f2),
        .release_mask(rel), .ready_set(rset),
        .issue_idx_1(i1), .issue_idx_2(i2),
        .issue_ack_1(ack1), .issue_ack_2(ack2),
        .busy_cnt(cnt), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nth_free(input int n);
        int c = 0;
        for (int i = 0; i < N; i++)
            if (!mb[i]) begin
                if (c == n) return i;
                c++;
            end
        return NONE;
    endfunction

    function automatic int nth_rdy(input int n);
        int c = 0;
        for (int k = 0; k < N; k++)
            if (mr[(mrr + k) % N]) begin
                if (c == n) return (mrr + k) % N;
                c++;
            end
        return NONE;
    endfunction

    function automatic int nbusy();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(mb[i]);
        return c;
    endfunction

    function automatic bit exp_g1();
        return rdy && !flush && req1 && nth_free(0) != NONE;
    endfunction

    function automatic bit exp_g2();
        return exp_g1() && req2 && nth_free(1) != NONE;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mb[i] = 0;
            mr[i] = 0;
        end
        mrr = 0;
    endtask

    task automatic model_step();
        int fa, fb, ia, ib;
        bit ga, gb, aa, ab;
        bit nb[N];
        if (!rdy) return;
        if (flush) begin
            model_clear();
            return;
        end
        fa = nth_free(0);
        fb = nth_free(1);
        ia = nth_rdy(0);
        ib = nth_rdy(1);
        ga = exp_g1();
        gb = exp_g2();
        aa = ack1 && ia != NONE;
        ab = aa && ack2 && ib != NONE;
        for (int i = 0; i < N; i++)
            nb[i] = (mb[i] && !rel[i]) || (ga && i == fa) || (gb && i == fb);
        for (int i = 0; i < N; i++)
            mr[i] = nb[i] && ((mr[i] && !(aa && i == ia) && !(ab && i == ib)) || rset[i]);
        mb = nb;
        if (ab) mrr = (ib + 1) % N;
        else if (aa) mrr = (ia + 1) % N;
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) model_clear();
        else model_step();

    always @(negedge clk)
        if (rst_n) begin
            chk("m_gnt1", 32'(g1), 32'(exp_g1()));
            chk("m_gnt2", 32'(g2), 32'(exp_g2()));
            chk("m_free1", 32'(f1), nth_free(0));
            chk("m_free2", 32'(f2), nth_free(1));
            chk("m_issue1", 32'(i1), nth_rdy(0));
            chk("m_issue2", 32'(i2), nth_rdy(1));
            chk("m_busy_cnt", 32'(cnt), nbusy());
            chk("m_full", 32'(full), 32'(nbusy() == N));
        end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_state(input string nm, input int ef1, input int ef2, input int ei1, input int ei2, input int ec, input int efull);
        chk({nm, "_free1"}, 32'(f1), ef1);
        chk({nm, "_free2"}, 32'(f2), ef2);
        chk({nm, "_issue1"}, 32'(i1), ei1);
        chk({nm, "_issue2"}, 32'(i2), ei2);
        chk({nm, "_busy_cnt"}, 32'(cnt), ec);
        chk({nm, "_full"}, 32'(full), efull);
    endtask

    initial begin
        #1 rst_n = 0;
        #2 lit_state("reset", 0, 1, 7, 7, 0, 0);
        #9 rst_n = 1;
        req1 = 1; req2 = 1;
        #1 chk("fill0_gnt1", 32'(g1), 1); chk("fill0_gnt2", 32'(g2), 1);
        cyc(); lit_state("fill1", 2, 3, 7, 7, 2, 0);
        chk("fill1_gnt1", 32'(g1), 1); chk("fill1_gnt2", 32'(g2), 1);
        cyc(); lit_state("fill2", 4, 5, 7, 7, 4, 0);
        cyc(); lit_state("fill3", 7, 7, 7, 7, 6, 1);
        chk("fill3_gnt1", 32'(g1), 0); chk("fill3_gnt2", 32'(g2), 0);
        req2 = 0; rel = 6'b000100;
        #1 chk("relsame_gnt1", 32'(g1), 0);
        cyc(); rel = '0;
        lit_state("rel", 2, 7, 7, 7, 5, 0);
        chk("realloc_gnt1", 32'(g1), 1);
        cyc(); req1 = 0;
        lit_state("refull", 7, 7, 7, 7, 6, 1);
        rset = 6'b111111;
        cyc(); rset = '0; ack1 = 1; ack2 = 1;
        lit_state("iss01", 7, 7, 0, 1, 6, 1);
        cyc(); lit_state("iss23", 7, 7, 2, 3, 6, 1);
        cyc(); lit_state("iss45", 7, 7, 4, 5, 6, 1);
        cyc(); ack1 = 0; ack2 = 0;
        lit_state("iss77", 7, 7, 7, 7, 6, 1);
        rset = 6'b100001;
        cyc(); rset = '0;
        lit_state("wrap", 7, 7, 0, 5, 6, 1);
        ack1 = 1; ack2 = 1;
        cyc(); ack1 = 0; ack2 = 0; rset = 6'b001000;
        cyc(); rset = '0; ack1 = 1;
        lit_state("iss3", 7, 7, 3, 7, 6, 1);
        cyc(); ack1 = 0; rset = 6'b000011;
        cyc(); rset = '0;
        lit_state("rr4", 7, 7, 0, 1, 6, 1);
        rset = 6'b010000; rel = 6'b010000;
        cyc(); rset = '0; rel = '0;
        lit_state("relrdy", 4, 7, 0, 1, 5, 0);
        rdy = 0; req1 = 1; req2 = 1; ack1 = 1; ack2 = 1; rel = '1; rset = '1;
        #1 chk("hold_gnt1", 32'(g1), 0); chk("hold_gnt2", 32'(g2), 0);
        repeat (3) cyc();
        lit_state("hold", 4, 7, 0, 1, 5, 0);
        rdy = 1; flush = 1;
        #1 chk("flush_gnt1", 32'(g1), 0);
        cyc(); flush = 0; req1 = 0; req2 = 0; ack1 = 0; ack2 = 0; rel = '0; rset = '0;
        lit_state("flush", 0, 1, 7, 7, 0, 0);
        req1 = 1; req2 = 1;
        cyc(); req2 = 0;
        #1 chk("pre_rst_gnt1", 32'(g1), 1);
        #1 rst_n = 0;
        #1 lit_state("midrst", 0, 1, 7, 7, 0, 0);
        #10 rst_n = 1;
        cyc(); req1 = 0;
        lit_state("postrst", 1, 2, 7, 7, 1, 0);
        for (int v = 0; v < 8; v++) begin
            {rdy, flush, req1, req2, ack1, ack2, rel, rset} = VEC[v];
            cyc();
        end
        {rdy, flush, req1, req2, ack1, ack2, rel, rset} = {6'b100000, 12'b0};
        cyc();
        lit_state("final", 0, 1, 7, 7, 0, 0);
        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
